phase_timer: RTL and testbench

//   Consumer of the per-state duration produced by the parameter block. Watches the

---
 rtl/phase_timer.sv | 131 +++++++++++++
 tb/tb_phase_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_timer.sv
// phase_timer: times each controller state for the ms duration given by the parameter block.
// Latency: with no pause, expired pulses t*TICK_DIV+1 edges after the edge that detects a state change.
// Backpressure: none (no handshake); pause freezes the countdown in RUN, clear aborts it.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   present_state  controller state code; any change (re)starts the timer
//   t              duration in ms for present_state, valid one cycle after the change
//   clear          synchronous abort to IDLE, no expired pulse
//   pause          holds prescaler and remaining_ms while in RUN
//   busy           high while counting (RUN)
//   expired        one-cycle pulse when the countdown reaches zero
//   remaining_ms   ms left in the current phase
//   done_state     state code whose timer last expired
module phase_timer #(
  parameter int TICK_DIV = 50000,
  parameter int T_W      = 19,
  parameter int S_W      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [S_W-1:0] present_state,
  input  logic [T_W-1:0] t,
  input  logic           clear,
  input  logic           pause,
  output logic           busy,
  output logic           expired,
  output logic [T_W-1:0] remaining_ms,
  output logic [S_W-1:0] done_state
);

  localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [S_W-1:0] prev_state_q;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [T_W-1:0] rem_q, rem_d;
  logic           expired_q, expired_d;
  logic [S_W-1:0] done_q, done_d;
  logic           chg;
  logic           tick;

  // prev_state resets to all-ones so the first state seen after reset counts as a change.
  assign chg  = (present_state != prev_state_q);
  assign tick = (presc_q == PS_LAST);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    rem_d     = rem_q;
    expired_d = 1'b0;
    done_d    = done_q;

    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      rem_d   = '0;
    end else if (chg) begin
      // A change always wins over the running count, even on its final tick.
      state_d = LOAD;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        LOAD: begin
          presc_d = '0;
          if (t == '0) begin
            // Untimed state: nothing to count, no pulse.
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            rem_d   = t;
            state_d = RUN;
          end
        end
        RUN: begin
          if (!pause) begin
            if (tick) begin
              presc_d = '0;
              if (rem_q != '0) begin
                rem_d = rem_q - T_W'(1);
                if (rem_q == T_W'(1)) begin
                  expired_d = 1'b1;
                  done_d    = present_state;
                  state_d   = DONE;
                end
              end
            end else begin
              presc_d = presc_q + PS_W'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prev_state_q <= '1;
      presc_q      <= '0;
      rem_q        <= '0;
      expired_q    <= 1'b0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      prev_state_q <= present_state;
      presc_q      <= presc_d;
      rem_q        <= rem_d;
      expired_q    <= expired_d;
      done_q       <= done_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign expired      = expired_q;
  assign remaining_ms = rem_q;
  assign done_state   = done_q;

endmodule

// File: tb/tb_phase_timer.sv
module tb_phase_timer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  present_state = 4'd0;
  logic [18:0] t = 19'd0;
  logic        clear = 1'b0;
  logic        pause = 1'b0;
  logic        busy;
  logic        expired;
  logic [18:0] remaining_ms;
  logic [3:0]  done_state;

  phase_timer #(.TICK_DIV(TD), .T_W(19), .S_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .present_state(present_state),
    .t            (t),
    .clear        (clear),
    .pause        (pause),
    .busy         (busy),
    .expired      (expired),
    .remaining_ms (remaining_ms),
    .done_state   (done_state)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pushed = 0;

  typedef struct {
    int         cyc;
    logic [3:0] st;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic [3:0] s);
    exp_t x;
    x.cyc = c;
    x.st  = s;
    sb.push_back(x);
    pushed++;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Every expired pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && expired) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_expired: pulse at cycle %0d, none expected", cyc);
      end else begin
        e = sb.pop_front();
        chk("expired_cycle", cyc, e.cyc);
        chk("expired_done_state", 32'(done_state), 32'(e.st));
      end
    end
  end

  typedef struct {
    logic [3:0]  st;
    logic [18:0] tv;
    int          pa;   // offset (falling edges after launch) where pause starts
    int          pl;   // pause length in cycles
  } vec_t;
  vec_t vecs[6];

  initial begin
    int n, m;
    bit busy_seen;
    logic [3:0] last_done;

    vecs[0] = '{4'd3, 19'd5, 5, 10};
    vecs[1] = '{4'd2, 19'd1, 0, 0};
    vecs[2] = '{4'd5, 19'd2, 3, 1};
    vecs[3] = '{4'd7, 19'd4, 6, 3};
    vecs[4] = '{4'd9, 19'd1, 2, 2};
    vecs[5] = '{4'd1, 19'd0, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_expired", 32'(expired), 0);
    chk("rst_remaining", 32'(remaining_ms), 0);
    chk("rst_done_state", 32'(done_state), 0);

    // Release with state 0 and t=3: change seen on the first edge after release
    t = 19'd3;
    rst_n = 1'b1;
    n = cyc;
    push_exp(n + 2 + 3*TD, 4'd0);
    wait_until(n + 1);
    chk("t1_busy_load", 32'(busy), 0);
    wait_until(n + 2);
    chk("t1_busy_run", 32'(busy), 1);
    chk("t1_rem3", 32'(remaining_ms), 3);
    wait_until(n + 6);
    chk("t1_rem2", 32'(remaining_ms), 2);
    wait_until(n + 10);
    chk("t1_rem1", 32'(remaining_ms), 1);
    wait_until(n + 13);
    chk("t1_busy_last", 32'(busy), 1);
    wait_until(n + 16);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_done_state", 32'(done_state), 0);
    last_done = 4'd0;

    // Table-driven phases, optionally paused mid-run
    for (int i = 0; i < 6; i++) begin
      present_state = vecs[i].st;
      t = vecs[i].tv;
      n = cyc;
      if (vecs[i].tv != 0) begin
        push_exp(n + 2 + int'(vecs[i].tv)*TD + vecs[i].pl, vecs[i].st);
        last_done = vecs[i].st;
      end
      busy_seen = 1'b0;
      for (int k = 1; k <= int'(vecs[i].tv)*TD + vecs[i].pl + 5; k++) begin
        @(negedge clk);
        pause = (k >= vecs[i].pa) && (k < vecs[i].pa + vecs[i].pl) && (vecs[i].pl > 0);
        if (busy) busy_seen = 1'b1;
        if (k == 2) chk("vec_rem_loaded", 32'(remaining_ms), 32'(vecs[i].tv));
      end
      pause = 1'b0;
      chk("vec_busy_seen", 32'(busy_seen), 32'(vecs[i].tv != 0));
      chk("vec_busy_end", 32'(busy), 0);
      chk("vec_rem_end", 32'(remaining_ms), 0);
      chk("vec_done_state", 32'(done_state), 32'(last_done));
    end

    // State switch mid-run: no pulse for 3, reload 2 for 4
    @(negedge clk);
    present_state = 4'd3;
    t = 19'd5;
    n = cyc;
    wait_until(n + 6);
    chk("t3_rem4", 32'(remaining_ms), 4);
    wait_until(n + 8);
    present_state = 4'd4;
    t = 19'd2;
    m = cyc;
    push_exp(m + 2 + 2*TD, 4'd4);
    wait_until(m + 1);
    chk("t3_busy_load", 32'(busy), 0);
    wait_until(m + 2);
    chk("t3_rem_reload", 32'(remaining_ms), 2);
    wait_until(m + 13);
    chk("t3_done_state", 32'(done_state), 4);

    // Change on the same edge as the final tick aborts the pulse
    present_state = 4'd6;
    t = 19'd1;
    n = cyc;
    wait_until(n + 5);
    present_state = 4'd8;
    t = 19'd0;
    wait_until(n + 6);
    chk("t5_expired_abort", 32'(expired), 0);
    chk("t5_busy_load", 32'(busy), 0);
    chk("t5_rem_held", 32'(remaining_ms), 1);
    wait_until(n + 7);
    chk("t5_rem_zero", 32'(remaining_ms), 0);

    // Clear in RUN
    @(negedge clk);
    present_state = 4'd10;
    t = 19'd3;
    n = cyc;
    wait_until(n + 5);
    chk("t5_busy_before_clear", 32'(busy), 1);
    clear = 1'b1;
    wait_until(n + 6);
    clear = 1'b0;
    chk("t5_clear_busy", 32'(busy), 0);
    chk("t5_clear_rem", 32'(remaining_ms), 0);
    wait_until(n + 20);
    chk("t5_clear_idle", 32'(busy), 0);

    // Change coincident with clear is discarded
    present_state = 4'd11;
    t = 19'd2;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    busy_seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("t5_clear_chg_no_run", 32'(busy_seen), 0);
    chk("t5_done_kept", 32'(done_state), 4);

    // Reset mid-run, then restart with the same state
    present_state = 4'd12;
    t = 19'd3;
    n = cyc;
    wait_until(n + 5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_rem", 32'(remaining_ms), 0);
    chk("t6_rst_expired", 32'(expired), 0);
    chk("t6_rst_done", 32'(done_state), 0);
    wait_until(n + 6);
    rst_n = 1'b1;
    m = cyc;
    push_exp(m + 2 + 3*TD, 4'd12);
    wait_until(m + 2);
    chk("t6_restart_rem", 32'(remaining_ms), 3);
    wait_until(m + 2 + 3*TD + 3);
    chk("t6_done_state", 32'(done_state), 12);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("pulse_count", 32'(pulses), 32'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
